// File: rtl/sync_rate_monitor_pkg.sv
// Shared types, derived-constant helpers and default constants for sync_rate_monitor.
package sync_rate_monitor_pkg;

  // Monitor state encoding
  typedef enum logic {
    ST_WAIT    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  // Nominal PPS period in system clocks
  function automatic int unsigned calc_per_nom(input int unsigned clk_hz,
                                               input int unsigned pps_s,
                                               input int unsigned pps_n);
    longint unsigned v;
    v = longint'(clk_hz) * longint'(pps_s) / longint'(pps_n);
    return 32'(v);
  endfunction

  // PPS tolerance in system clocks; multiply first so sub-MHz clocks keep resolution
  function automatic int unsigned calc_per_tol(input int unsigned clk_hz,
                                               input int unsigned pps_tol_us);
    longint unsigned v;
    v = longint'(clk_hz) * longint'(pps_tol_us) / 64'd1000000;
    return 32'(v);
  endfunction

  // Expected SYNC edges per PPS interval
  function automatic int unsigned calc_exp_cnt(input int unsigned clk_sync_hz,
                                               input int unsigned pps_s,
                                               input int unsigned pps_n);
    longint unsigned v;
    v = longint'(clk_sync_hz) * longint'(pps_s) / longint'(pps_n);
    return 32'(v);
  endfunction

  // |err| <= tol for a sign-extended error; 33-bit magnitude avoids overflow at the most negative value
  function automatic logic abs_le(input logic signed [31:0] err, input int unsigned tol);
    logic [32:0] ext;
    logic [32:0] mag;
    ext = {err[31], err};
    mag = ext[32] ? (~ext + 33'd1) : ext;
    return mag <= {1'b0, tol};
  endfunction

  // Constants for the default 40 MHz / 10 PPS-per-second configuration
  localparam int unsigned def_per_nom  = calc_per_nom(32'd40000000, 32'd1, 32'd10);
  localparam int unsigned def_per_tol  = calc_per_tol(32'd40000000, 32'd500);
  localparam int unsigned def_exp_cnt  = calc_exp_cnt(32'd1000, 32'd1, 32'd10);
  localparam int unsigned def_per_bits = $clog2(def_per_nom + def_per_tol + 2);

endpackage

// File: rtl/sync_rate_monitor_edge_det.sv
// Two-flop synchroniser with previous-value register and single-cycle edge pulse.
module sync_edge_det
  import sync_rate_monitor_pkg::*;
#(
  parameter bit RISING = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_edge_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the synchroniser chain
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and history registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_edge_c = RISING ? (sync_q & ~prev_q) : (~sync_q & prev_q);

endmodule

// File: rtl/sync_rate_monitor.sv
// Measures PPS period and per-channel SYNC counts per PPS interval, with tolerance and lock status.
module sync_rate_monitor
  import sync_rate_monitor_pkg::*;
#(
  parameter int unsigned clk_hz      = 40000000,
  parameter int unsigned pps_n       = 10,
  parameter int unsigned pps_s       = 1,
  parameter int unsigned pps_tol_us  = 500,
  parameter int unsigned clk_sync_hz = 1000,
  parameter int unsigned n_ch        = 2,
  parameter int unsigned cnt_bits    = 16,
  parameter int unsigned err_tol     = 1,
  parameter int unsigned lock_n      = 4,
  localparam int unsigned per_nom    = calc_per_nom(clk_hz, pps_s, pps_n),
  localparam int unsigned per_tol    = calc_per_tol(clk_hz, pps_tol_us),
  localparam int unsigned exp_cnt    = calc_exp_cnt(clk_sync_hz, pps_s, pps_n),
  localparam int unsigned per_bits   = $clog2(per_nom + per_tol + 2)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_pps,
  input  logic [n_ch-1:0]            i_sync,
  output logic [per_bits-1:0]        o_period,
  output logic [n_ch*cnt_bits-1:0]   o_count,
  output logic [n_ch*cnt_bits-1:0]   o_err,
  output logic [n_ch-1:0]            o_ch_ok,
  output logic                       o_pps_valid,
  output logic                       o_locked,
  output logic                       o_update
);

  localparam int unsigned lock_bits = $clog2(lock_n + 1);
  localparam int unsigned per_lo    = per_nom - per_tol;
  localparam int unsigned per_hi    = per_nom + per_tol;

  logic                 pps_edge_c;
  logic [n_ch-1:0]      sync_edge_c;

  state_e                          state_q, state_d;
  logic [per_bits-1:0]             per_cnt_q, per_cnt_d;
  logic [n_ch-1:0][cnt_bits-1:0]   cnt_q, cnt_d;
  logic [per_bits-1:0]             period_q, period_d;
  logic [n_ch-1:0][cnt_bits-1:0]   count_q, count_d;
  logic [n_ch-1:0][cnt_bits-1:0]   err_q, err_d;
  logic [n_ch-1:0]                 ch_ok_q, ch_ok_d;
  logic                            pps_valid_q, pps_valid_d;
  logic                            locked_q, locked_d;
  logic [lock_bits-1:0]            lock_cnt_q, lock_cnt_d;
  logic                            update_q, update_d;
  logic                            good_c;

  // PPS rising-edge detector
  sync_edge_det #(.RISING(1'b1)) u_pps_det (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_d      (i_pps),
    .o_edge_c (pps_edge_c)
  );

  // SYNC falling-edge detectors, one per channel
  for (genvar g = 0; g < int'(n_ch); g++) begin : g_sync
    sync_edge_det #(.RISING(1'b0)) u_sync_det (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_d      (i_sync[g]),
      .o_edge_c (sync_edge_c[g])
    );
  end

  // Next-state, counters and latched results
  always_comb begin
    state_d     = state_q;
    per_cnt_d   = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 1'b1;
    cnt_d       = cnt_q;
    period_d    = period_q;
    count_d     = count_q;
    err_d       = err_q;
    ch_ok_d     = ch_ok_q;
    pps_valid_d = pps_valid_q;
    locked_d    = locked_q;
    lock_cnt_d  = lock_cnt_q;
    update_d    = 1'b0;
    good_c      = 1'b0;

    for (int unsigned k = 0; k < n_ch; k++) begin
      if (sync_edge_c[k] && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end

    case (state_q)
      ST_WAIT: begin
        if (pps_edge_c) begin
          state_d   = ST_MEASURE;
          per_cnt_d = '0;
          for (int unsigned k = 0; k < n_ch; k++) begin
            cnt_d[k] = sync_edge_c[k] ? cnt_bits'(1) : '0;
          end
        end
      end

      ST_MEASURE: begin
        if (pps_edge_c) begin
          period_d    = per_cnt_q + 1'b1;
          pps_valid_d = (period_d >= per_bits'(per_lo)) && (period_d <= per_bits'(per_hi));
          for (int unsigned k = 0; k < n_ch; k++) begin
            count_d[k] = cnt_q[k];
            err_d[k]   = cnt_q[k] - cnt_bits'(exp_cnt);
            ch_ok_d[k] = abs_le(32'(signed'(err_d[k])), err_tol);
            // A coincident SYNC edge opens the new interval rather than closing the old one
            cnt_d[k]   = sync_edge_c[k] ? cnt_bits'(1) : '0;
          end
          good_c = pps_valid_d && (&ch_ok_d);
          if (!good_c) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q != lock_bits'(lock_n)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
          locked_d  = (lock_cnt_d == lock_bits'(lock_n));
          update_d  = 1'b1;
          per_cnt_d = '0;
        end else if (per_cnt_q >= per_bits'(per_hi)) begin
          state_d     = ST_WAIT;
          pps_valid_d = 1'b0;
          locked_d    = 1'b0;
          lock_cnt_d  = '0;
          ch_ok_d     = '0;
        end
      end

      default: state_d = ST_WAIT;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_WAIT;
      per_cnt_q   <= '0;
      cnt_q       <= '0;
      period_q    <= '0;
      count_q     <= '0;
      err_q       <= '0;
      ch_ok_q     <= '0;
      pps_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      lock_cnt_q  <= '0;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      count_q     <= count_d;
      err_q       <= err_d;
      ch_ok_q     <= ch_ok_d;
      pps_valid_q <= pps_valid_d;
      locked_q    <= locked_d;
      lock_cnt_q  <= lock_cnt_d;
      update_q    <= update_d;
    end
  end

  assign o_period    = period_q;
  assign o_count     = count_q;
  assign o_err       = err_q;
  assign o_ch_ok     = ch_ok_q;
  assign o_pps_valid = pps_valid_q;
  assign o_locked    = locked_q;
  assign o_update    = update_q;

endmodule

// File: tb/tb_sync_rate_monitor.sv
// Randomised bench for sync_rate_monitor against an interval-level reference model.
module tb_sync_rate_monitor;

  localparam int N_CH     = 2;
  localparam int PER_NOM  = 10000;
  localparam int PER_TOL  = 5;
  localparam int EXP_CNT  = 100;
  localparam int ERR_TOL  = 1;
  localparam int LOCK_N   = 4;
  localparam int LAT      = 3;

  typedef struct packed {
    int               due;
    int               period;
    logic             valid;
    logic [1:0][15:0] cnt;
    logic [1:0][15:0] err;
    logic [1:0]       ok;
    logic             locked;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_pps = 1'b0;
  logic [1:0]  i_sync = 2'b11;
  logic [13:0] o_period;
  logic [31:0] o_count;
  logic [31:0] o_err;
  logic [1:0]  o_ch_ok;
  logic        o_pps_valid;
  logic        o_locked;
  logic        o_update;

  int total = 0;
  int bad = 0;

  // model state: input-domain cycle numbers
  int n = 0;
  int sper[N_CH] = '{100, 100};
  int next_fall[N_CH] = '{1000000, 1000000};
  bit measuring = 0;
  int last = 0;
  int mcnt[N_CH] = '{0, 0};
  int run = 0;
  int to_chk_at = -1;
  logic [1:0][15:0] last_cnt = '0;
  logic [1:0][15:0] last_err = '0;
  exp_t q[$];

  always #5 clk = ~clk;

  sync_rate_monitor #(
    .clk_hz(10000), .pps_n(1), .pps_s(1), .pps_tol_us(500), .clk_sync_hz(100),
    .n_ch(2), .cnt_bits(16), .err_tol(1), .lock_n(4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_pps       (i_pps),
    .i_sync      (i_sync),
    .o_period    (o_period),
    .o_count     (o_count),
    .o_err       (o_err),
    .o_ch_ok     (o_ch_ok),
    .o_pps_valid (o_pps_valid),
    .o_locked    (o_locked),
    .o_update    (o_update)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Interval-level reference: a report per PPS that closes a live interval
  task automatic model(input bit pps_now, input bit [1:0] fall);
    exp_t e;
    if (measuring && !pps_now && (n - last) > PER_NOM + PER_TOL) begin
      measuring = 0;
      run = 0;
      to_chk_at = n + 12;
    end
    if (pps_now) begin
      if (measuring) begin
        e.due    = n + LAT;
        e.period = n - last;
        e.valid  = (e.period >= PER_NOM - PER_TOL) && (e.period <= PER_NOM + PER_TOL);
        for (int k = 0; k < N_CH; k++) begin
          e.cnt[k] = 16'(mcnt[k]);
          e.err[k] = 16'(mcnt[k] - EXP_CNT);
          e.ok[k]  = (mcnt[k] - EXP_CNT <= ERR_TOL) && (EXP_CNT - mcnt[k] <= ERR_TOL);
        end
        run      = (e.valid && (&e.ok)) ? run + 1 : 0;
        e.locked = (run >= LOCK_N);
        q.push_back(e);
        last_cnt = e.cnt;
        last_err = e.err;
      end
      measuring = 1;
      last = n;
      for (int k = 0; k < N_CH; k++) mcnt[k] = int'(fall[k]);
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (fall[k] && mcnt[k] < 65535) mcnt[k]++;
    end
  endtask

  task automatic tick(input bit pps_now);
    bit [1:0] fall;
    @(posedge clk);
    #1;
    n++;
    i_pps = pps_now;
    for (int k = 0; k < N_CH; k++) begin
      fall[k] = (n == next_fall[k]);
      if (fall[k]) next_fall[k] += sper[k];
    end
    i_sync = ~fall;
    if (n == to_chk_at) begin
      chk("timeout_valid", o_pps_valid, 0);
      chk("timeout_locked", o_locked, 0);
      chk("timeout_ch_ok", o_ch_ok, 0);
      chk("timeout_count_hold", o_count, last_cnt);
      chk("timeout_err_hold", o_err, last_err);
    end
    model(pps_now, fall);
  endtask

  task automatic wait_gap(input int g);
    repeat (g - 1) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic do_reset(input int cyc);
    @(posedge clk);
    #1;
    n++;
    i_rst = 1'b1;
    i_pps = 1'b0;
    i_sync = 2'b11;
    #1;
    chk("rst_period", o_period, 0);
    chk("rst_count", o_count, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ch_ok", o_ch_ok, 0);
    chk("rst_valid", o_pps_valid, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_update", o_update, 0);
    repeat (cyc - 1) begin
      @(posedge clk);
      #1;
      n++;
    end
    i_rst = 1'b0;
    measuring = 0;
    run = 0;
    last_cnt = '0;
    last_err = '0;
    chk("rst_queue_empty", q.size(), 0);
    for (int k = 0; k < N_CH; k++) next_fall[k] = n + 1 + int'($urandom_range(0, 50));
  endtask

  // Compare every update strobe against the oldest expected report
  always @(negedge clk) begin
    exp_t e;
    if (!i_rst) begin
      if (q.size() > 0 && n > q[0].due) begin
        chk("missed_update", 0, 1);
        void'(q.pop_front());
      end
      if (o_update === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_update", 1, 0);
        end else begin
          e = q.pop_front();
          chk("update_cycle", n, e.due);
          chk("period", o_period, e.period);
          chk("pps_valid", o_pps_valid, e.valid);
          chk("count", o_count, e.cnt);
          chk("err", o_err, e.err);
          chk("ch_ok", o_ch_ok, e.ok);
          chk("locked", o_locked, e.locked);
        end
      end
    end
  end

  initial begin
    do_reset(3);
    repeat (5) tick(1'b0);

    // nominal, SYNC falls coincident with every PPS
    sper[0] = 100;
    sper[1] = 100;
    next_fall[0] = n + 20;
    next_fall[1] = n + 20;
    wait_gap(20);
    repeat (4) wait_gap(PER_NOM);

    // channel 1 fast, PPS at upper edge of window
    sper[1] = 98;
    wait_gap(PER_NOM + PER_TOL);

    // PPS just outside window, random near-nominal SYNC rates
    sper[0] = int'($urandom_range(97, 103));
    sper[1] = int'($urandom_range(97, 103));
    wait_gap(PER_NOM + PER_TOL + 1);

    // short PPS interval, random SYNC rates
    sper[0] = int'($urandom_range(2, 200));
    sper[1] = int'($urandom_range(2, 200));
    wait_gap(int'($urandom_range(2000, 3000)));

    // missing PPS: timeout, restart without report, then a report
    repeat (PER_NOM + 100) tick(1'b0);
    wait_gap(50);
    sper[0] = int'($urandom_range(90, 110));
    wait_gap(int'($urandom_range(3000, 4000)));

    // reset mid-interval
    repeat (2000) tick(1'b0);
    do_reset(3);
    sper[0] = int'($urandom_range(2, 150));
    sper[1] = int'($urandom_range(2, 150));
    wait_gap(1000);
    wait_gap(int'($urandom_range(2000, 2500)));

    repeat (20) tick(1'b0);
    chk("pending_reports", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
